// File: rtl/correlator_bank_reader.sv
// Read-back engine for the cos/sin correlator accumulators.
// It walks a retired bank from cell 0 to WORDS-1 and streams the cos half,
// then the sin half, of each packed word over a valid/ready interface.
module correlator_bank_reader #(
  parameter int unsigned ACCUM = 24,
  parameter int unsigned WORDS = 24,
  parameter int unsigned ABITS = 5,
  parameter int unsigned BBITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     swap,
  input  logic [BBITS-1:0]         bank_i,
  output logic                     ram_rd,
  output logic [BBITS+ABITS-1:0]   ram_adr,
  input  logic [2*ACCUM-1:0]       ram_dat,
  output logic [ACCUM-1:0]         dat_o,
  output logic                     vld_o,
  input  logic                     rdy_i,
  output logic                     last_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND_COS,
    SEND_SIN
  } state_t;

  localparam logic [ABITS-1:0] LAST_CELL = ABITS'(WORDS - 1);

  state_t                   state_q, state_d;
  logic [BBITS-1:0]         bank_q, bank_d;
  logic [ABITS-1:0]         cell_q, cell_d;
  logic [2*ACCUM-1:0]       hold_q, hold_d;
  logic                     sel_sin_q, sel_sin_d;
  logic                     ram_rd_q, ram_rd_d;
  logic [BBITS+ABITS-1:0]   ram_adr_q, ram_adr_d;
  logic                     vld_q, vld_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;

  logic                     xfer;
  logic                     at_last_cell;
  logic [ABITS-1:0]         cell_inc;

  assign xfer         = vld_q & rdy_i;
  assign at_last_cell = (cell_q == LAST_CELL);
  assign cell_inc     = cell_q + ABITS'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q    <= '0;
      cell_q    <= '0;
      hold_q    <= '0;
      sel_sin_q <= 1'b0;
      ram_rd_q  <= 1'b0;
      ram_adr_q <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      cell_q    <= cell_d;
      hold_q    <= hold_d;
      sel_sin_q <= sel_sin_d;
      ram_rd_q  <= ram_rd_d;
      ram_adr_q <= ram_adr_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state and next-output logic. The RAM read strobe is registered on
  // the transition into FETCH so it is high exactly for the FETCH cycle.
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    cell_d    = cell_q;
    hold_d    = hold_q;
    sel_sin_d = sel_sin_q;
    ram_rd_d  = 1'b0;
    ram_adr_d = ram_adr_q;
    vld_d     = vld_q;
    last_d    = last_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    // A swap while busy (including on the final transfer) is dropped.
    if (swap && busy_q) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (swap && !busy_q) begin
          bank_d    = bank_i;
          cell_d    = '0;
          busy_d    = 1'b1;
          ram_rd_d  = 1'b1;
          ram_adr_d = {bank_i, {ABITS{1'b0}}};
          state_d   = FETCH;
        end
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        hold_d    = ram_dat;
        sel_sin_d = 1'b0;
        vld_d     = 1'b1;
        state_d   = SEND_COS;
      end
      SEND_COS: begin
        if (xfer) begin
          sel_sin_d = 1'b1;
          last_d    = at_last_cell;
          state_d   = SEND_SIN;
        end
      end
      SEND_SIN: begin
        if (xfer) begin
          vld_d = 1'b0;
          if (at_last_cell) begin
            last_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cell_d    = cell_inc;
            ram_rd_d  = 1'b1;
            ram_adr_d = {bank_q, cell_inc};
            state_d   = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // dat_o is selected from the holding register; the select only flips on a
  // cos transfer or on entry to SEND_COS, so the stream stays stable in stalls.
  assign dat_o     = sel_sin_q ? hold_q[2*ACCUM-1:ACCUM] : hold_q[ACCUM-1:0];
  assign ram_rd    = ram_rd_q;
  assign ram_adr   = ram_adr_q;
  assign vld_o     = vld_q;
  assign last_o    = last_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule
